// File: rtl/pcie_cntl_cpld_tx.sv
// Completion transmitter for the register slave.
// Captures one register-read completion request, formats the CC descriptor
// plus up to two payload DWs, and presents the result as a single AXI4-Stream beat.
module pcie_cntl_cpld_tx #(
    parameter int C_PCIE_DATA_WIDTH = 512
) (
    input  logic                           pcie_user_clk,
    input  logic                           pcie_user_rst,

    input  logic                           tx_cpld_req,
    input  logic [7:0]                     tx_cpld_tag,
    input  logic [15:0]                    tx_cpld_req_id,
    input  logic [12:2]                    tx_cpld_len,
    input  logic [6:0]                     tx_cpld_laddr,
    input  logic [63:0]                    tx_cpld_data,
    input  logic [2:0]                     tx_cpld_tc,
    input  logic [2:0]                     tx_cpld_attr,
    input  logic [1:0]                     tx_cpld_at,
    input  logic [7:0]                     tx_cpld_be,
    output logic                           tx_cpld_req_ack,

    output logic [C_PCIE_DATA_WIDTH-1:0]   s_axis_cc_tdata,
    output logic [C_PCIE_DATA_WIDTH/32-1:0] s_axis_cc_tkeep,
    output logic                           s_axis_cc_tlast,
    output logic                           s_axis_cc_tvalid,
    input  logic                           s_axis_cc_tready,

    output logic                           cpld_busy,
    output logic                           cpld_len_err
);

    localparam int KW = C_PCIE_DATA_WIDTH / 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    state_t      r_state;

    // Captured request fields; the beat in flight is built only from these.
    logic [7:0]  r_tag;
    logic [15:0] r_req_id;
    logic [10:0] r_len;
    logic [4:0]  r_laddr;
    logic [63:0] r_data;
    logic [2:0]  r_tc;
    logic [2:0]  r_attr;
    logic [1:0]  r_at;
    logic [7:0]  r_be;

    logic                         w_len1;
    logic                         w_len2;
    logic                         w_len_bad;
    logic [1:0]                   w_low_idx;
    logic [2:0]                   w_first_tz;
    logic [2:0]                   w_last_lz;
    logic [12:0]                  w_byte_cnt;
    logic [2:0]                   w_status;
    logic [10:0]                  w_dw_cnt;
    logic [31:0]                  w_dw0;
    logic [31:0]                  w_dw1;
    logic [31:0]                  w_dw2;
    logic [C_PCIE_DATA_WIDTH-1:0] w_tdata;
    logic [KW-1:0]                w_tkeep;
    logic                         w_in_len_bad;
    logic                         w_unused;

    // The two low address bits are implied by the first BE, not carried.
    assign w_unused     = ^tx_cpld_laddr[1:0];
    assign w_in_len_bad = (tx_cpld_len != 11'd1) && (tx_cpld_len != 11'd2);

    assign w_len1    = (r_len == 11'd1);
    assign w_len2    = (r_len == 11'd2);
    assign w_len_bad = !(w_len1 || w_len2);

    // Descriptor and payload formatting from the captured request.
    always_comb begin
        // lowest enabled byte of the first DW (also its trailing-zero count)
        w_low_idx  = 2'd0;
        w_first_tz = 3'd4;
        if (r_be[0]) begin
            w_low_idx  = 2'd0;
            w_first_tz = 3'd0;
        end else if (r_be[1]) begin
            w_low_idx  = 2'd1;
            w_first_tz = 3'd1;
        end else if (r_be[2]) begin
            w_low_idx  = 2'd2;
            w_first_tz = 3'd2;
        end else if (r_be[3]) begin
            w_low_idx  = 2'd3;
            w_first_tz = 3'd3;
        end

        // highest enabled byte of the last DW, counted from the top
        w_last_lz = 3'd4;
        if (r_be[7])      w_last_lz = 3'd0;
        else if (r_be[6]) w_last_lz = 3'd1;
        else if (r_be[5]) w_last_lz = 3'd2;
        else if (r_be[4]) w_last_lz = 3'd3;

        w_byte_cnt = 13'd1;
        if (w_len_bad) begin
            w_byte_cnt = 13'd4;
        end else if (w_len2) begin
            w_byte_cnt = 13'd8 - {10'd0, w_first_tz} - {10'd0, w_last_lz};
        end else begin
            casez (r_be[3:0])
                4'b1??1:                   w_byte_cnt = 13'd4;
                4'b01?1, 4'b1?10:          w_byte_cnt = 13'd3;
                4'b0011, 4'b0110, 4'b1100: w_byte_cnt = 13'd2;
                default:                   w_byte_cnt = 13'd1;
            endcase
        end

        // unsupported lengths complete as Unsupported Request with no data
        w_status = w_len_bad ? 3'b001 : 3'b000;
        w_dw_cnt = w_len_bad ? 11'd0 : r_len;

        w_dw0 = {3'b000, w_byte_cnt, 6'd0, r_at, 1'b0, r_laddr, w_low_idx};
        w_dw1 = {r_req_id, 2'b00, w_status, w_dw_cnt};
        w_dw2 = {1'b0, r_attr, r_tc, 17'd0, r_tag};

        w_tdata         = '0;
        w_tdata[31:0]   = w_dw0;
        w_tdata[63:32]  = w_dw1;
        w_tdata[95:64]  = w_dw2;
        if (!w_len_bad) begin
            w_tdata[127:96] = r_data[31:0];
        end
        if (w_len2) begin
            w_tdata[159:128] = r_data[63:32];
        end

        w_tkeep = '0;
        if (w_len_bad)   w_tkeep[4:0] = 5'b00111;
        else if (w_len2) w_tkeep[4:0] = 5'b11111;
        else             w_tkeep[4:0] = 5'b01111;
    end

    // Request capture / beat build / beat hand-off state machine.
    always_ff @(posedge pcie_user_clk) begin
        if (pcie_user_rst) begin
            r_state          <= ST_IDLE;
            tx_cpld_req_ack  <= 1'b0;
            cpld_len_err     <= 1'b0;
            s_axis_cc_tvalid <= 1'b0;
            s_axis_cc_tdata  <= '0;
            s_axis_cc_tkeep  <= '0;
            r_tag            <= '0;
            r_req_id         <= '0;
            r_len            <= '0;
            r_laddr          <= '0;
            r_data           <= '0;
            r_tc             <= '0;
            r_attr           <= '0;
            r_at             <= '0;
            r_be             <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (tx_cpld_req) begin
                        r_tag           <= tx_cpld_tag;
                        r_req_id        <= tx_cpld_req_id;
                        r_len           <= tx_cpld_len;
                        r_laddr         <= tx_cpld_laddr[6:2];
                        r_data          <= tx_cpld_data;
                        r_tc            <= tx_cpld_tc;
                        r_attr          <= tx_cpld_attr;
                        r_at            <= tx_cpld_at;
                        r_be            <= tx_cpld_be;
                        tx_cpld_req_ack <= 1'b1;
                        cpld_len_err    <= w_in_len_bad;
                        r_state         <= ST_BUILD;
                    end
                end
                ST_BUILD: begin
                    tx_cpld_req_ack  <= 1'b0;
                    cpld_len_err     <= 1'b0;
                    s_axis_cc_tdata  <= w_tdata;
                    s_axis_cc_tkeep  <= w_tkeep;
                    s_axis_cc_tvalid <= 1'b1;
                    r_state          <= ST_SEND;
                end
                ST_SEND: begin
                    if (s_axis_cc_tready) begin
                        s_axis_cc_tvalid <= 1'b0;
                        r_state          <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis_cc_tlast = s_axis_cc_tvalid;
    assign cpld_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pcie_cntl_cpld_tx.sv
// Directed bench for the CC completion transmitter.
module tb_pcie_cntl_cpld_tx;

    logic         clk;
    logic         rst;
    logic         req;
    logic [7:0]   tag;
    logic [15:0]  req_id;
    logic [10:0]  len;
    logic [6:0]   laddr;
    logic [63:0]  data;
    logic [2:0]   tc;
    logic [2:0]   attr;
    logic [1:0]   at;
    logic [7:0]   be;
    logic         ack;
    logic [511:0] tdata;
    logic [15:0]  tkeep;
    logic         tlast;
    logic         tvalid;
    logic         tready;
    logic         busy;
    logic         len_err;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int beat_a_cyc;
    int beat_b_cyc;
    logic [511:0] snap;

    pcie_cntl_cpld_tx #(.C_PCIE_DATA_WIDTH(512)) dut (
        .pcie_user_clk    (clk),
        .pcie_user_rst    (rst),
        .tx_cpld_req      (req),
        .tx_cpld_tag      (tag),
        .tx_cpld_req_id   (req_id),
        .tx_cpld_len      (len),
        .tx_cpld_laddr    (laddr),
        .tx_cpld_data     (data),
        .tx_cpld_tc       (tc),
        .tx_cpld_attr     (attr),
        .tx_cpld_at       (at),
        .tx_cpld_be       (be),
        .tx_cpld_req_ack  (ack),
        .s_axis_cc_tdata  (tdata),
        .s_axis_cc_tkeep  (tkeep),
        .s_axis_cc_tlast  (tlast),
        .s_axis_cc_tvalid (tvalid),
        .s_axis_cc_tready (tready),
        .cpld_busy        (busy),
        .cpld_len_err     (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk(input logic [31:0] d0, input logic [31:0] d1,
                                        input logic [31:0] d2, input logic [31:0] d3,
                                        input logic [31:0] d4);
        logic [511:0] v;
        v = '0;
        v[159:0] = {d4, d3, d2, d1, d0};
        return v;
    endfunction

    task automatic drive(input logic [7:0] t, input logic [15:0] rid, input logic [10:0] l,
                         input logic [6:0] la, input logic [63:0] d, input logic [7:0] b);
        tag = t; req_id = rid; len = l; laddr = la; data = d; be = b;
        tc = 3'd0; attr = 3'd0; at = 2'd0;
        req = 1'b1;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; tag = '0; req_id = '0; len = '0; laddr = '0;
        data = '0; tc = '0; attr = '0; at = '0; be = '0; tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", {511'd0, tvalid}, 512'd0);
        chk("rst_ack", {511'd0, ack}, 512'd0);
        chk("rst_busy", {511'd0, busy}, 512'd0);
        chk("rst_tdata", tdata, 512'd0);
        chk("rst_tkeep", {496'd0, tkeep}, 512'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic 1-DW read
        drive(8'h5A, 16'h0100, 11'd1, 7'h14, 64'h00000000_DEADBEEF, 8'h0F);
        @(negedge clk);
        chk("b1_ack", {511'd0, ack}, 512'd1);
        chk("b1_busy", {511'd0, busy}, 512'd1);
        chk("b1_tvalid_early", {511'd0, tvalid}, 512'd0);
        req = 1'b0;
        @(negedge clk);
        chk("b1_tvalid", {511'd0, tvalid}, 512'd1);
        chk("b1_ack_drop", {511'd0, ack}, 512'd0);
        chk("b1_tdata", tdata, mk(32'h0004_0014, 32'h0100_0001, 32'h0000_005A, 32'hDEADBEEF, 32'h0));
        chk("b1_tkeep", {496'd0, tkeep}, 512'h000F);
        chk("b1_tlast", {511'd0, tlast}, 512'd1);
        @(negedge clk);
        chk("b1_done_tvalid", {511'd0, tvalid}, 512'd0);
        chk("b1_done_busy", {511'd0, busy}, 512'd0);

        // 2-DW read with TC/attr/AT
        drive(8'h77, 16'hABCD, 11'd2, 7'h30, 64'h11223344_55667788, 8'hFF);
        tc = 3'd5; attr = 3'd2; at = 2'd1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("b2_tdata", tdata, mk(32'h0008_0130, 32'hABCD_0002, 32'h2A00_0077, 32'h55667788, 32'h11223344));
        chk("b2_tkeep", {496'd0, tkeep}, 512'h001F);
        @(negedge clk);

        // 2-DW read with partial first/last BE: 8 - 1 - 2 = 5 bytes
        drive(8'h01, 16'h0000, 11'd2, 7'h04, 64'h00000002_00000001, 8'h3E);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("b2p_tdata", tdata, mk(32'h0005_0005, 32'h0000_0002, 32'h0000_0001, 32'h1, 32'h2));
        @(negedge clk);

        // Partial BE, 1 DW
        drive(8'h02, 16'h0100, 11'd1, 7'h08, 64'h0000000A_12345678, 8'h06);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("pbe_tdata", tdata, mk(32'h0002_0009, 32'h0100_0001, 32'h0000_0002, 32'h12345678, 32'h0));
        @(negedge clk);

        // Backpressure: 5 stalled cycles, req held high throughout
        tready = 1'b0;
        drive(8'h33, 16'h0200, 11'd1, 7'h00, 64'h0_CAFEF00D, 8'h0F);
        @(negedge clk);
        @(negedge clk);
        snap = mk(32'h0004_0000, 32'h0200_0001, 32'h0000_0033, 32'hCAFEF00D, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_tvalid_%0d", i), {511'd0, tvalid}, 512'd1);
            chk($sformatf("bp_tdata_%0d", i), tdata, snap);
            chk($sformatf("bp_ack_%0d", i), {511'd0, ack}, 512'd0);
            if (i < 4) @(negedge clk);
        end
        tready = 1'b1;
        req = 1'b0;
        @(negedge clk);
        chk("bp_accept_tvalid", {511'd0, tvalid}, 512'd0);
        chk("bp_accept_busy", {511'd0, busy}, 512'd0);
        chk("bp_accept_ack", {511'd0, ack}, 512'd0);

        // Length error
        drive(8'h10, 16'h0300, 11'd4, 7'h04, 64'hFFFFFFFF_FFFFFFFF, 8'h0F);
        @(negedge clk);
        chk("le_pulse", {511'd0, len_err}, 512'd1);
        req = 1'b0;
        @(negedge clk);
        chk("le_pulse_end", {511'd0, len_err}, 512'd0);
        chk("le_tdata", tdata, mk(32'h0004_0004, 32'h0300_0800, 32'h0000_0010, 32'h0, 32'h0));
        chk("le_tkeep", {496'd0, tkeep}, 512'h0007);
        @(negedge clk);

        // Reset mid-SEND
        tready = 1'b0;
        drive(8'h44, 16'h0100, 11'd1, 7'h00, 64'h1, 8'h0F);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("rs_tvalid_before", {511'd0, tvalid}, 512'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rs_tvalid", {511'd0, tvalid}, 512'd0);
        chk("rs_busy", {511'd0, busy}, 512'd0);
        tready = 1'b1;
        @(negedge clk);
        chk("rs_no_replay", {511'd0, tvalid}, 512'd0);

        // Back-to-back, req kept high with new fields right after the first ack
        drive(8'hA1, 16'h0100, 11'd1, 7'h00, 64'h0, 8'h0F);
        @(negedge clk);
        chk("bb_ack1", {511'd0, ack}, 512'd1);
        tag = 8'hB2;
        @(negedge clk);
        beat_a_cyc = cyc;
        chk("bb_tvalid1", {511'd0, tvalid}, 512'd1);
        chk("bb_tag1", {480'd0, tdata[95:64]}, 512'h0000_00A1);
        @(negedge clk);
        chk("bb_gap_tvalid", {511'd0, tvalid}, 512'd0);
        @(negedge clk);
        chk("bb_ack2", {511'd0, ack}, 512'd1);
        req = 1'b0;
        @(negedge clk);
        beat_b_cyc = cyc;
        chk("bb_tvalid2", {511'd0, tvalid}, 512'd1);
        chk("bb_tag2", {480'd0, tdata[95:64]}, 512'h0000_00B2);
        chk("bb_spacing", 512'(beat_b_cyc - beat_a_cyc), 512'd3);
        @(negedge clk);
        chk("bb_end_tvalid", {511'd0, tvalid}, 512'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
